matdet5_seq: RTL

MATDET5_SEQ -- requirements
Module: matdet5_seq

---
 rtl/matdet5_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/matdet5_seq.sv
// ---------------------------------------------------------------------------
// matdet5_seq
// Sequential 5x5 determinant, modulo 2^DATA_WIDTH. The determinant is expanded
// along row 0. One 4x4 determinant block and one multiplier are shared across
// five CALC cycles, one cofactor per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a holds a matrix to be evaluated
//   in_ready   block can accept a matrix (state IDLE)
//   a          row-major 5x5 matrix, element (r,c) at [(5r+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  det holds a completed result (state DONE)
//   out_ready  consumer takes det this cycle
//   det        determinant modulo 2^DATA_WIDTH
//   busy       high in every state except IDLE
// ---------------------------------------------------------------------------

// Wrapping DATA_WIDTH x DATA_WIDTH multiplier. Only the low product bits are kept.
module matdet5_mul #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_p
);
   assign o_p = i_a * i_b;
endmodule

// Combinational 4x4 determinant, modulo 2^DATA_WIDTH.
// The input is a row-major 4x4 matrix with element (r,c) at [(4r+c)*DATA_WIDTH].
module matdet5_det4 #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [16*DATA_WIDTH-1:0] i_m,
   output logic [DATA_WIDTH-1:0]    o_det
);
   logic [DATA_WIDTH-1:0] w_e [16];
   logic [DATA_WIDTH-1:0] w_c0, w_c1, w_c2, w_c3;

   function automatic logic [DATA_WIDTH-1:0] f_det3(
      input logic [DATA_WIDTH-1:0] a0, input logic [DATA_WIDTH-1:0] a1,
      input logic [DATA_WIDTH-1:0] a2, input logic [DATA_WIDTH-1:0] a3,
      input logic [DATA_WIDTH-1:0] a4, input logic [DATA_WIDTH-1:0] a5,
      input logic [DATA_WIDTH-1:0] a6, input logic [DATA_WIDTH-1:0] a7,
      input logic [DATA_WIDTH-1:0] a8);
      return a0 * (a4 * a8 - a5 * a7)
           - a1 * (a3 * a8 - a5 * a6)
           + a2 * (a3 * a7 - a4 * a6);
   endfunction

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         w_e[i] = i_m[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // 3x3 minors of row 0, column j removed from rows 1..3
   assign w_c0 = f_det3(w_e[5], w_e[6], w_e[7],  w_e[9], w_e[10], w_e[11], w_e[13], w_e[14], w_e[15]);
   assign w_c1 = f_det3(w_e[4], w_e[6], w_e[7],  w_e[8], w_e[10], w_e[11], w_e[12], w_e[14], w_e[15]);
   assign w_c2 = f_det3(w_e[4], w_e[5], w_e[7],  w_e[8], w_e[9],  w_e[11], w_e[12], w_e[13], w_e[15]);
   assign w_c3 = f_det3(w_e[4], w_e[5], w_e[6],  w_e[8], w_e[9],  w_e[10], w_e[12], w_e[13], w_e[14]);

   assign o_det = w_e[0] * w_c0 - w_e[1] * w_c1 + w_e[2] * w_c2 - w_e[3] * w_c3;
endmodule

module matdet5_seq #(
   parameter int DATA_WIDTH  = 8,
   parameter int MATRIX_SIZE = 25
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_WIDTH-1:0]             det,
   output logic                              busy
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                            r_state;
   state_t                            w_state_nxt;
   logic [MATRIX_SIZE*DATA_WIDTH-1:0] r_mat;
   logic [2:0]                        r_col;
   logic [DATA_WIDTH-1:0]             r_acc;
   logic [DATA_WIDTH-1:0]             r_det;

   logic [16*DATA_WIDTH-1:0]          w_minor;
   logic [DATA_WIDTH-1:0]             w_pivot;
   logic [DATA_WIDTH-1:0]             w_det4;
   logic [DATA_WIDTH-1:0]             w_term;
   logic [DATA_WIDTH-1:0]             w_acc_nxt;

   // Minor of row 0 / column r_col. Columns left of r_col keep their position,
   // columns right of it shift left by one.
   always_comb begin
      w_minor = '0;
      for (int r = 1; r < 5; r++) begin
         for (int c = 0; c < 4; c++) begin
            w_minor[((r-1)*4+c)*DATA_WIDTH +: DATA_WIDTH] =
               r_mat[(5*r + ((c < int'(r_col)) ? c : c + 1))*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_pivot = r_mat[int'(r_col)*DATA_WIDTH +: DATA_WIDTH];

   matdet5_det4 #(.DATA_WIDTH(DATA_WIDTH)) u_det4 (
      .i_m   (w_minor),
      .o_det (w_det4)
   );

   matdet5_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
      .i_a (w_pivot),
      .i_b (w_det4),
      .o_p (w_term)
   );

   // Cofactor signs alternate +,-,+,-,+ with the column index
   assign w_acc_nxt = r_col[0] ? (r_acc - w_term) : (r_acc + w_term);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (in_valid)        w_state_nxt = CALC;
         CALC:    if (r_col == 3'd4)   w_state_nxt = DONE;
         DONE:    if (out_ready)       w_state_nxt = IDLE;
         default:                      w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= 3'd0;
         r_acc <= '0;
         r_det <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mat <= a;
                  r_acc <= '0;
                  r_col <= 3'd0;
               end
            end
            CALC: begin
               r_acc <= w_acc_nxt;
               r_col <= r_col + 3'd1;
               if (r_col == 3'd4) begin
                  r_det <= w_acc_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign det       = r_det;
endmodule
